// File: rtl/sha3_absorb_padder.sv
// sha3_absorb_padder
// Packs a byte stream into RATE_BYTES-wide sponge blocks and applies the
// FIPS 202 multi-rate padding (DSBYTE ... 0x80) to the final block.
//
// Handshake rules (both ports): a transfer happens at a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until that edge; valid never drops before its transfer completes.
// ready may sit high indefinitely.
module sha3_absorb_padder #(
    parameter int          RATE_BYTES = 136,
    parameter logic [7:0]  DSBYTE     = 8'h06
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [RATE_BYTES*8-1:0] blk_data,
    output logic                    blk_valid,
    output logic                    blk_last,
    input  logic                    blk_ready
);

    localparam int             W        = RATE_BYTES * 8;
    localparam int             CW       = $clog2(RATE_BYTES + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(RATE_BYTES - 1);

    // FILL : collecting message bytes
    // PAD  : stamping DSBYTE / 0x80 into a partially filled final block
    // OUT  : presenting a block downstream
    // EXTRA: building the pad-only block that follows an exactly full last block
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        OUT   = 2'd2,
        EXTRA = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [W-1:0]  blk_buf, blk_buf_d;
    logic          last_q, last_d;
    logic          pend_q, pend_d;

    // State, byte count, block buffer and flags; reset drops any partial or pending block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            cnt     <= '0;
            blk_buf <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            blk_buf <= blk_buf_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state, byte placement and padding for the block buffer.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        blk_buf_d = blk_buf;
        last_d    = last_q;
        pend_d    = pend_q;

        case (state)
            FILL: begin
                if (in_valid) begin
                    for (int i = 0; i < RATE_BYTES; i++) begin
                        if (cnt == CW'(i)) begin
                            blk_buf_d[i*8 +: 8] = in_data;
                        end
                    end
                    cnt_d = cnt + CW'(1);
                    if (cnt == LAST_IDX) begin
                        // Block is full; if it was also the last byte, padding
                        // has no room left and goes into a separate block.
                        state_d = OUT;
                        last_d  = 1'b0;
                        pend_d  = in_last;
                    end else if (in_last) begin
                        state_d = PAD;
                    end
                end
            end

            PAD: begin
                // cnt already points one past the last message byte.
                for (int i = 0; i < RATE_BYTES; i++) begin
                    if (cnt == CW'(i)) begin
                        blk_buf_d[i*8 +: 8] = blk_buf_d[i*8 +: 8] | DSBYTE;
                    end
                    if (i == RATE_BYTES - 1) begin
                        blk_buf_d[i*8 +: 8] = blk_buf_d[i*8 +: 8] | 8'h80;
                    end
                end
                state_d = OUT;
                last_d  = 1'b1;
            end

            OUT: begin
                if (blk_ready) begin
                    blk_buf_d = '0;
                    cnt_d     = '0;
                    if (pend_q) begin
                        state_d = EXTRA;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            EXTRA: begin
                blk_buf_d             = '0;
                blk_buf_d[7:0]        = DSBYTE;
                blk_buf_d[W-1 -: 8]   = blk_buf_d[W-1 -: 8] | 8'h80;
                state_d               = OUT;
                last_d                = 1'b1;
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign in_ready  = (state == FILL) && !rst;
    assign blk_valid = (state == OUT);
    assign blk_last  = last_q;
    assign blk_data  = blk_buf;

endmodule

// File: tb/tb_sha3_absorb_padder.sv
// Self-checking bench for sha3_absorb_padder: SHA3-256 instance driven from a
// vector table plus hand-written reset/stall/latency sequences, and a
// SHA3-512-rate SHAKE-domain instance for the parameter corner.
module tb_sha3_absorb_padder;

    localparam int RB  = 136;
    localparam int RB2 = 72;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // main instance (136 B, 0x06)
    logic [7:0]      in_data;
    logic            in_valid, in_last, in_ready;
    logic [RB*8-1:0] blk_data;
    logic            blk_valid, blk_last, blk_ready;

    // second instance (72 B, 0x1F)
    logic [7:0]       in_data_b;
    logic             in_valid_b, in_last_b, in_ready_b;
    logic [RB2*8-1:0] blk_data_b;
    logic             blk_valid_b, blk_last_b, blk_ready_b;

    sha3_absorb_padder #(.RATE_BYTES(RB), .DSBYTE(8'h06)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready)
    );

    sha3_absorb_padder #(.RATE_BYTES(RB2), .DSBYTE(8'h1F)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_last(in_last_b), .in_ready(in_ready_b),
        .blk_data(blk_data_b), .blk_valid(blk_valid_b), .blk_last(blk_last_b), .blk_ready(blk_ready_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [RB*8-1:0] act, input logic [RB*8-1:0] exp);
        int first;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            first = -1;
            for (int i = RB - 1; i >= 0; i--) begin
                if (act[i*8 +: 8] !== exp[i*8 +: 8]) first = i;
            end
            $display("FAIL %s byte %0d act=%02h exp=%02h", name, first,
                     act[first*8 +: 8], exp[first*8 +: 8]);
        end
    endtask

    // captured output blocks of the main instance
    logic [RB*8-1:0] cap_data[$];
    logic            cap_last[$];

    // a handshake happens at the next posedge iff valid&ready are high now
    always @(negedge clk) begin
        if (!rst && blk_valid && blk_ready) begin
            cap_data.push_back(blk_data);
            cap_last.push_back(blk_last);
        end
    end

    // ---------------- driver tasks ----------------
    bit auto_rdy = 1'b1;

    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_rdy) blk_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_msg(input int len, input logic [7:0] base, input bit do_last);
        int t;
        bit acc;
        for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b1;   // in_last without in_valid must be ignored
                in_data  = 8'hEE;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = 8'(int'(base) + j);
            in_last  = do_last && (j == len - 1);
            t = 0;
            acc = 1'b0;
            while (!acc && t < 2000) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                check_val("input_accept_timeout", 32'(t), 32'(0));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         len;      // message length in bytes
        logic [7:0] base;     // byte j of the message = base + j
        int         nblk;     // expected number of blocks
        int         pad_pos;  // index of DSBYTE in the final block
        bit         stall;    // hold blk_ready low on the first block
    } vec_t;

    vec_t vecs[6];

    task automatic stall_watch();
        logic [RB*8-1:0] snap;
        int t;
        t = 0;
        while (t < 3000) begin
            @(negedge clk);
            if (blk_valid) break;
            t++;
        end
        check_val("stall_valid_seen", 32'(blk_valid), 32'(1));
        snap = blk_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("stall_valid_held", 32'(blk_valid), 32'(1));
            check_val("stall_in_ready", 32'(in_ready), 32'(0));
            check_val("stall_last", 32'(blk_last), 32'(0));
            check_blk("stall_data_stable", blk_data, snap);
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [RB*8-1:0] exp;
        int t;
        int m;
        cap_data.delete();
        cap_last.delete();
        if (v.stall) begin
            auto_rdy  = 1'b0;
            blk_ready = 1'b0;
            fork
                send_msg(v.len, v.base, 1'b1);
                stall_watch();
            join
            auto_rdy = 1'b1;
        end else begin
            send_msg(v.len, v.base, 1'b1);
        end
        t = 0;
        while (cap_data.size() < v.nblk && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (20) @(posedge clk);
        #1;
        check_val($sformatf("v%0d_block_count", id), 32'(cap_data.size()), 32'(v.nblk));
        for (int b = 0; b < v.nblk && b < cap_data.size(); b++) begin
            exp = '0;
            for (int j = 0; j < RB; j++) begin
                m = b * RB + j;
                if (m < v.len) exp[j*8 +: 8] = 8'(int'(v.base) + m);
            end
            if (b == v.nblk - 1) begin
                exp[v.pad_pos*8 +: 8] = exp[v.pad_pos*8 +: 8] | 8'h06;
                exp[(RB-1)*8 +: 8]    = exp[(RB-1)*8 +: 8] | 8'h80;
            end
            check_blk($sformatf("v%0d_blk%0d_data", id, b), cap_data[b], exp);
            check_val($sformatf("v%0d_blk%0d_last", id, b), 32'(cap_last[b]), 32'(b == v.nblk - 1));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [RB*8-1:0] exp_b;
        int t;

        vecs[0] = '{3,   8'h61, 1, 3,   1'b0};  // "abc"
        vecs[1] = '{135, 8'h00, 1, 135, 1'b0};  // DSBYTE and 0x80 merge into 0x86
        vecs[2] = '{136, 8'h00, 2, 0,   1'b0};  // exact fit -> pad-only block
        vecs[3] = '{200, 8'h00, 2, 64,  1'b0};  // spills 64 bytes into block 2
        vecs[4] = '{1,   8'hAA, 1, 1,   1'b0};  // single byte
        vecs[5] = '{140, 8'h10, 2, 4,   1'b1};  // downstream stall on block 1

        rst         = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data_b   = 8'h00;
        in_valid_b  = 1'b0;
        in_last_b   = 1'b0;
        blk_ready_b = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_in_ready", 32'(in_ready), 32'(0));
        check_val("reset_blk_valid", 32'(blk_valid), 32'(0));
        check_val("reset_blk_last", 32'(blk_last), 32'(0));
        check_blk("reset_blk_data", blk_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_reset_in_ready", 32'(in_ready), 32'(1));
        check_val("post_reset_in_ready_b", 32'(in_ready_b), 32'(1));
        @(posedge clk);
        #1;

        // table-driven messages, back to back
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // reset in the middle of a block, then "abc" must come out clean
        cap_data.delete();
        cap_last.delete();
        send_msg(50, 8'h30, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_in_ready_after", 32'(in_ready), 32'(1));
        check_val("midrst_no_block", 32'(cap_data.size()), 32'(0));
        @(posedge clk);
        #1;
        run_vec(vecs[0], 10);

        // 72-byte rate, SHAKE domain: one byte AA, padded-block latency of 2
        in_valid_b = 1'b1;
        in_data_b  = 8'hAA;
        in_last_b  = 1'b1;
        @(negedge clk);
        check_val("b_in_ready", 32'(in_ready_b), 32'(1));
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        in_last_b  = 1'b0;
        @(negedge clk);
        check_val("b_valid_after_1", 32'(blk_valid_b), 32'(0));
        @(negedge clk);
        check_val("b_valid_after_2", 32'(blk_valid_b), 32'(1));
        check_val("b_last", 32'(blk_last_b), 32'(1));
        exp_b = '0;
        exp_b[7:0]                = 8'hAA;
        exp_b[15:8]               = 8'h1F;
        exp_b[(RB2-1)*8 +: 8]     = 8'h80;
        check_blk("b_data", {{(RB-RB2)*8{1'b0}}, blk_data_b}, exp_b);
        check_val("b_in_ready_busy", 32'(in_ready_b), 32'(0));
        @(posedge clk);
        #1;
        blk_ready_b = 1'b1;
        t = 0;
        while (blk_valid_b && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        check_val("b_valid_cleared", 32'(blk_valid_b), 32'(0));
        check_val("b_in_ready_again", 32'(in_ready_b), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
